pac_rr_req_queue: RTL and testbench

PAC_RR_REQ_QUEUE -- requirements
Module: pac_rr_req_queue

---
 rtl/pac_rr_req_queue_pkg.sv | 11 +
 rtl/pac_rr_chan_fifo.sv | 82 ++++++++
 rtl/pac_rr_req_queue.sv | 112 +++++++++++
 tb/tb_pac_rr_req_queue.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pac_rr_req_queue_pkg.sv
// Shared sizing constants for the per-channel request queue.
package pac_rr_req_queue_pkg;

  localparam int PAC_N         = 4;  // requester channels
  localparam int PAC_DEPTH     = 4;  // entries per channel FIFO
  localparam int PAC_DW        = 8;  // payload width
  localparam int PAC_IDX_WIDTH = 2;  // log2(PAC_N)
  localparam int PAC_CNT_W     = 3;  // occupancy counter width (0..PAC_DEPTH)
  localparam int PAC_PTR_W     = 2;  // read/write pointer width

endpackage : pac_rr_req_queue_pkg

// File: rtl/pac_rr_chan_fifo.sv
// Single-channel FIFO: registered pointers and count, unreset storage,
// head entry presented combinationally from the read pointer.
module pac_rr_chan_fifo
  import pac_rr_req_queue_pkg::*;
#(
  parameter int DEPTH = PAC_DEPTH,
  parameter int DW    = PAC_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic [DW-1:0]        push_data_i,
  input  logic                 pop_i,
  output logic [PAC_CNT_W-1:0] count_o,
  output logic [DW-1:0]        head_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [DW-1:0]        mem_q [DEPTH];
  logic [PAC_PTR_W-1:0] rptr_q, rptr_d;
  logic [PAC_PTR_W-1:0] wptr_q, wptr_d;
  logic [PAC_CNT_W-1:0] count_q, count_d;
  logic                 push_ok;
  logic                 pop_ok;

  // Guard locally so a misbehaving caller can never corrupt the count.
  assign full_o  = (count_q == PAC_CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  function automatic logic [PAC_PTR_W-1:0] ptr_inc(input logic [PAC_PTR_W-1:0] p);
    return (p == PAC_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for pointers and count; clear overrides any push or pop.
  always_comb begin
    // NOTE: every variable gets its default before any branch, so no latch is inferred.
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (clear_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = ptr_inc(wptr_q);
      if (pop_ok)  rptr_d = ptr_inc(rptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage write; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; zeroed pointers and count make stale data unreachable.
    if (push_ok) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule : pac_rr_chan_fifo

// File: rtl/pac_rr_req_queue.sv
// Per-channel request queues feeding an external round-robin arbiter:
// push demux, one-hot grant check, head mux and sticky error flags.
module pac_rr_req_queue
  import pac_rr_req_queue_pkg::*;
#(
  parameter int N         = PAC_N,
  parameter int DEPTH     = PAC_DEPTH,
  parameter int DW        = PAC_DW,
  parameter int IDX_WIDTH = PAC_IDX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_valid_i,
  input  logic [IDX_WIDTH-1:0]   push_ch_i,
  input  logic [DW-1:0]          push_data_i,
  output logic                   push_ready_o,
  output logic [N-1:0]           req_o,
  input  logic [N-1:0]           grant_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [DW-1:0]          data_o,
  output logic [N*PAC_CNT_W-1:0] level_o,
  input  logic                   clear_i,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  logic [N-1:0]         full;
  logic [N-1:0]         empty;
  logic [N-1:0]         push_sel;
  logic [N-1:0]         pop_sel;
  logic [DW-1:0]        head  [N];
  logic [PAC_CNT_W-1:0] count [N];

  logic                 grant_onehot;
  logic [IDX_WIDTH-1:0] gnt_idx;
  logic                 push_fire;
  logic                 pop_fire;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  // Ready comes from registered fullness only, never from pop/grant.
  assign push_ready_o = !full[push_ch_i];
  assign push_fire    = push_valid_i && push_ready_o;

  assign grant_onehot = (grant_i != '0) && ((grant_i & (grant_i - 1'b1)) == '0);

  // Encode the granted channel index; only meaningful when the grant is one-hot.
  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_i[k]) gnt_idx = IDX_WIDTH'(k);
    end
  end

  // A push into an empty channel is not bypassed: req_o is registered state.
  assign valid_o  = grant_onehot && req_o[gnt_idx];
  assign data_o   = valid_o ? head[gnt_idx] : '0;
  assign pop_fire = pop_i && valid_o;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign push_sel[k] = push_fire && (push_ch_i == IDX_WIDTH'(k));
    assign pop_sel[k]  = pop_fire && grant_i[k];

    pac_rr_chan_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (clear_i),
      .push_i      (push_sel[k]),
      .push_data_i (push_data_i),
      .pop_i       (pop_sel[k]),
      .count_o     (count[k]),
      .head_o      (head[k]),
      .full_o      (full[k]),
      .empty_o     (empty[k])
    );

    assign req_o[k]                          = !empty[k];
    assign level_o[k*PAC_CNT_W +: PAC_CNT_W] = count[k];
  end

  // Sticky flag next-state; clear wins over a same-cycle error event.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_valid_i && !push_ready_o) overflow_d  = 1'b1;
      if (pop_i && !valid_o)             underflow_d = 1'b1;
    end
  end

  // Sticky flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule : pac_rr_req_queue

// File: tb/tb_pac_rr_req_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared against a queue-based reference model of the channel FIFOs.
module tb_pac_rr_req_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid_i;
  logic [1:0]  push_ch_i;
  logic [7:0]  push_data_i;
  logic        push_ready_o;
  logic [3:0]  req_o;
  logic [3:0]  grant_i;
  logic        pop_i;
  logic        valid_o;
  logic [7:0]  data_o;
  logic [11:0] level_o;
  logic        clear_i;
  logic        overflow_o;
  logic        underflow_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: one unbounded queue per channel, capped at 4 by rule.
  logic [7:0] mq [4][$];
  logic       m_ovf;
  logic       m_unf;

  pac_rr_req_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (push_valid_i),
    .push_ch_i    (push_ch_i),
    .push_data_i  (push_data_i),
    .push_ready_o (push_ready_o),
    .req_o        (req_o),
    .grant_i      (grant_i),
    .pop_i        (pop_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .level_o      (level_o),
    .clear_i      (clear_i),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk = ~clk;

  function automatic int m_gidx();
    int g;
    g = -1;
    if ($countones(grant_i) == 1) begin
      for (int k = 0; k < 4; k++) if (grant_i[k]) g = k;
    end
    return g;
  endfunction

  function automatic logic m_valid();
    int g;
    g = m_gidx();
    return (g >= 0) && (mq[g].size() > 0);
  endfunction

  function automatic logic [7:0] m_data();
    int g;
    g = m_gidx();
    if (g >= 0 && mq[g].size() > 0) return mq[g][0];
    return 8'h00;
  endfunction

  function automatic logic [3:0] m_req();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (mq[k].size() != 0);
    return r;
  endfunction

  function automatic logic [11:0] m_level();
    logic [11:0] l;
    for (int k = 0; k < 4; k++) l[k*3 +: 3] = 3'(mq[k].size());
    return l;
  endfunction

  function automatic logic m_ready();
    return mq[push_ch_i].size() < 4;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic rdy;
    logic vld;
    int   g;
    if (!rst_n || clear_i) begin
      for (int k = 0; k < 4; k++) mq[k].delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rdy = m_ready();
      vld = m_valid();
      g   = m_gidx();
      if (push_valid_i && !rdy) m_ovf = 1'b1;
      if (pop_i && !vld)        m_unf = 1'b1;
      if (pop_i && vld)         void'(mq[g].pop_front());
      if (push_valid_i && rdy)  mq[push_ch_i].push_back(push_data_i);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid_i = 1'b0;
    push_ch_i    = 2'd0;
    push_data_i  = 8'h00;
    grant_i      = 4'b0000;
    pop_i        = 1'b0;
    clear_i      = 1'b0;
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    push_valid_i = 1'b1;
    push_ch_i    = ch;
    push_data_i  = d;
    tick();
    push_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    total_cnt++; if (req_o !== 4'b0000) $display("FAIL reset_req: got %b want 0000", req_o); else pass_cnt++;
    total_cnt++; if (level_o !== 12'h000) $display("FAIL reset_level: got %h want 000", level_o); else pass_cnt++;
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else pass_cnt++;
    total_cnt++; if (data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", data_o); else pass_cnt++;
    total_cnt++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow_o); else pass_cnt++;
    total_cnt++; if (underflow_o !== 1'b0) $display("FAIL reset_unf: got %b want 0", underflow_o); else pass_cnt++;
    total_cnt++; if (push_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", push_ready_o); else pass_cnt++;
  endtask

  task automatic test_basic();
    idle();
    push(2'd2, 8'hA1);
    total_cnt++; if (req_o !== 4'b0100) $display("FAIL basic_req: got %b want 0100", req_o); else pass_cnt++;
    push(2'd2, 8'hB2);
    total_cnt++; if (level_o[8:6] !== 3'd2) $display("FAIL basic_level: got %0d want 2", level_o[8:6]); else pass_cnt++;
    grant_i = 4'b0100;
    #1;
    total_cnt++; if (valid_o !== 1'b1) $display("FAIL basic_valid: got %b want 1", valid_o); else pass_cnt++;
    total_cnt++; if (data_o !== 8'hA1) $display("FAIL basic_head0: got %h want a1", data_o); else pass_cnt++;
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
    #1;
    total_cnt++; if (data_o !== 8'hB2) $display("FAIL basic_head1: got %h want b2", data_o); else pass_cnt++;
    pop_i = 1'b1;
    tick();
    idle();
    #1;
    total_cnt++; if (req_o !== 4'b0000) $display("FAIL basic_drain: got %b want 0000", req_o); else pass_cnt++;
  endtask

  task automatic test_overflow();
    idle();
    push_valid_i = 1'b1;
    push_ch_i    = 2'd0;
    for (int i = 0; i < 5; i++) begin
      push_data_i = 8'(8'h10 + i);
      #1;
      total_cnt++;
      if (push_ready_o !== (i < 4)) $display("FAIL ovf_ready%0d: got %b want %b", i, push_ready_o, (i < 4));
      else pass_cnt++;
      tick();
    end
    idle();
    #1;
    total_cnt++; if (overflow_o !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow_o); else pass_cnt++;
    total_cnt++; if (level_o[2:0] !== 3'd4) $display("FAIL ovf_level: got %0d want 4", level_o[2:0]); else pass_cnt++;
    grant_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if (data_o !== 8'(8'h10 + i)) $display("FAIL ovf_order%0d: got %h want %h", i, data_o, 8'(8'h10 + i));
      else pass_cnt++;
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
    end
    idle();
    #1;
    total_cnt++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow_o); else pass_cnt++;
    total_cnt++; if (underflow_o !== 1'b0) $display("FAIL ovf_no_unf: got %b want 0", underflow_o); else pass_cnt++;
    clear_i = 1'b1;
    tick();
    idle();
    total_cnt++; if (overflow_o !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", overflow_o); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    logic [7:0] warm [2]    = '{8'h01, 8'h02};
    logic [7:0] fill [3]    = '{8'h11, 8'h22, 8'h33};
    logic [7:0] tail [3]    = '{8'h22, 8'h33, 8'h55};
    idle();
    // Two warm-up entries move ch1 pointers to 2 so the later traffic wraps.
    for (int i = 0; i < 2; i++) push(2'd1, warm[i]);
    grant_i = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++; if (data_o !== warm[i]) $display("FAIL same_warm%0d: got %h want %h", i, data_o, warm[i]); else pass_cnt++;
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
    end
    idle();
    for (int i = 0; i < 3; i++) push(2'd1, fill[i]);
    grant_i      = 4'b0010;
    pop_i        = 1'b1;
    push_valid_i = 1'b1;
    push_ch_i    = 2'd1;
    push_data_i  = 8'h55;
    #1;
    total_cnt++; if (data_o !== 8'h11) $display("FAIL same_head: got %h want 11", data_o); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (level_o[5:3] !== 3'd3) $display("FAIL same_level: got %0d want 3", level_o[5:3]); else pass_cnt++;
    grant_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (data_o !== tail[i]) $display("FAIL same_order%0d: got %h want %h", i, data_o, tail[i]); else pass_cnt++;
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
    end
    idle();
    #1;
    total_cnt++; if (req_o !== 4'b0000) $display("FAIL same_drain: got %b want 0000", req_o); else pass_cnt++;
  endtask

  task automatic test_underflow();
    idle();
    push(2'd0, 8'h9C);
    grant_i = 4'b0011;
    pop_i   = 1'b1;
    #1;
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL unf_multi_valid: got %b want 0", valid_o); else pass_cnt++;
    total_cnt++; if (data_o !== 8'h00) $display("FAIL unf_multi_data: got %h want 00", data_o); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (underflow_o !== 1'b1) $display("FAIL unf_flag: got %b want 1", underflow_o); else pass_cnt++;
    total_cnt++; if (level_o !== m_level()) $display("FAIL unf_level0: got %h want %h", level_o, m_level()); else pass_cnt++;
    grant_i = 4'b1000;
    pop_i   = 1'b1;
    #1;
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL unf_empty_valid: got %b want 0", valid_o); else pass_cnt++;
    total_cnt++; if (data_o !== 8'h00) $display("FAIL unf_empty_data: got %h want 00", data_o); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (level_o !== 12'h001) $display("FAIL unf_level1: got %h want 001", level_o); else pass_cnt++;
    // Push into empty ch3 with a same-cycle pop: no bypass, the pop is illegal.
    push_valid_i = 1'b1;
    push_ch_i    = 2'd3;
    push_data_i  = 8'h3C;
    grant_i      = 4'b1000;
    pop_i        = 1'b1;
    #1;
    total_cnt++; if (valid_o !== 1'b0) $display("FAIL unf_bypass: got %b want 0", valid_o); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (level_o[11:9] !== 3'd1) $display("FAIL unf_ch3_level: got %0d want 1", level_o[11:9]); else pass_cnt++;
    clear_i = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_clear_and_reset();
    idle();
    push(2'd0, 8'hC0);
    push(2'd3, 8'hC3);
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
    for (int i = 0; i < 4; i++) push(2'd0, 8'(8'hD0 + i));
    total_cnt++; if ({overflow_o, underflow_o} !== 2'b11) $display("FAIL clr_pre_flags: got %b want 11", {overflow_o, underflow_o}); else pass_cnt++;
    clear_i      = 1'b1;
    push_valid_i = 1'b1;
    push_ch_i    = 2'd1;
    push_data_i  = 8'hEE;
    tick();
    idle();
    total_cnt++; if (req_o !== 4'b0000) $display("FAIL clr_req: got %b want 0000", req_o); else pass_cnt++;
    total_cnt++; if (level_o !== 12'h000) $display("FAIL clr_level: got %h want 000", level_o); else pass_cnt++;
    total_cnt++; if ({overflow_o, underflow_o} !== 2'b00) $display("FAIL clr_flags: got %b want 00", {overflow_o, underflow_o}); else pass_cnt++;
    // Reset in the middle of traffic.
    push(2'd1, 8'h41);
    push(2'd1, 8'h42);
    push(2'd2, 8'h43);
    pop_i = 1'b1;
    tick();
    pop_i        = 1'b0;
    rst_n        = 1'b0;
    push_valid_i = 1'b1;
    push_ch_i    = 2'd1;
    push_data_i  = 8'h44;
    tick();
    rst_n = 1'b1;
    idle();
    total_cnt++; if (req_o !== 4'b0000) $display("FAIL rst_req: got %b want 0000", req_o); else pass_cnt++;
    total_cnt++; if (level_o !== 12'h000) $display("FAIL rst_level: got %h want 000", level_o); else pass_cnt++;
    total_cnt++; if ({overflow_o, underflow_o} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {overflow_o, underflow_o}); else pass_cnt++;
    total_cnt++; if (push_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", push_ready_o); else pass_cnt++;
    push(2'd1, 8'h77);
    push(2'd1, 8'h88);
    grant_i = 4'b0010;
    #1;
    total_cnt++; if (data_o !== 8'h77) $display("FAIL rst_first: got %h want 77", data_o); else pass_cnt++;
    clear_i = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n        = ($urandom_range(0, 149) != 0);
      clear_i      = ($urandom_range(0, 59) == 0);
      push_valid_i = ($urandom_range(0, 2) != 0);
      push_ch_i    = 2'($urandom_range(0, 3));
      push_data_i  = 8'($urandom);
      pop_i        = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 4) != 0) grant_i = 4'b0001 << $urandom_range(0, 3);
      else                           grant_i = 4'($urandom);
      #1;
      total_cnt++; if (push_ready_o !== m_ready()) $display("FAIL rnd_ready c%0d: got %b want %b", c, push_ready_o, m_ready()); else pass_cnt++;
      total_cnt++; if (req_o !== m_req()) $display("FAIL rnd_req c%0d: got %b want %b", c, req_o, m_req()); else pass_cnt++;
      total_cnt++; if (level_o !== m_level()) $display("FAIL rnd_level c%0d: got %h want %h", c, level_o, m_level()); else pass_cnt++;
      total_cnt++; if (valid_o !== m_valid()) $display("FAIL rnd_valid c%0d: got %b want %b", c, valid_o, m_valid()); else pass_cnt++;
      total_cnt++; if (data_o !== m_data()) $display("FAIL rnd_data c%0d: got %h want %h", c, data_o, m_data()); else pass_cnt++;
      total_cnt++; if (overflow_o !== m_ovf) $display("FAIL rnd_ovf c%0d: got %b want %b", c, overflow_o, m_ovf); else pass_cnt++;
      total_cnt++; if (underflow_o !== m_unf) $display("FAIL rnd_unf c%0d: got %b want %b", c, underflow_o, m_unf); else pass_cnt++;
      tick();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_overflow();
    test_same_cycle();
    test_underflow();
    test_clear_and_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_pac_rr_req_queue
